// File: rtl/mult_16_seq.sv
// mult_16_seq: 16x16 unsigned sequential shift-add multiplier.
// One shift-add step per RUN cycle, fixed 16-cycle latency, registered
// busy/done flags and a product register that only moves on completion.
module mult_16_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] p
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] mc_q, mc_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] p_q, p_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [16:0] sum;

  // Next-state logic: accept in IDLE/DONE, one shift-add step per RUN cycle.
  always_comb begin
    state_d = state_q;
    mc_d    = mc_q;
    acc_d   = acc_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    // 17-bit sum keeps the carry-out so it lands in acc[31] after the shift.
    sum     = {1'b0, acc_q[31:16]} + (acc_q[0] ? {1'b0, mc_q} : 17'd0);
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mc_d    = a;
          acc_d   = {16'h0000, b};
          cnt_d   = 4'd0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = {sum, acc_q[15:1]};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = DONE;
          p_d     = {sum, acc_q[15:1]};
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mc_q    <= 16'h0000;
      acc_q   <= 32'h0000_0000;
      p_q     <= 32'h0000_0000;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mc_q    <= mc_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = p_q;

endmodule

// File: tb/tb_mult_16_seq.sv
// Bench for mult_16_seq: reference model + scoreboard queue, monitor on the
// falling edge, directed scenarios followed by randomized traffic.
module tb_mult_16_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = 16'h0;
  logic [15:0] b = 16'h0;
  logic        busy, done;
  logic [31:0] p;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: an operation is "in flight" for 16 cycles after being
  // accepted, then reports its product for one cycle.
  int          m_cnt  = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_p    = 32'h0;
  logic [31:0] m_pend = 32'h0;
  logic [31:0] sb_q[$];

  mult_16_seq dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .p    (p)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  = 0;
      m_done = 1'b0;
      m_p    = 32'h0;
      sb_q.delete();
    end else if (m_cnt > 0) begin
      m_cnt--;
      m_done = (m_cnt == 0);
      if (m_cnt == 0) m_p = m_pend;
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_pend = 32'(a) * 32'(b);
        sb_q.push_back(m_pend);
        m_cnt = 16;
      end
    end
  end

  // Monitor: flags and product every cycle, scoreboard pop on each done.
  always @(negedge clk) begin
    if (!rst) begin
      logic [31:0] exp_p;
      chk("busy", {31'b0, busy}, {31'b0, (m_cnt > 0)});
      chk("done", {31'b0, done}, {31'b0, m_done});
      chk("p_model", p, m_p);
      if (done) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_empty: done seen with no expected product, p=%h", p);
        end else begin
          exp_p = sb_q.pop_front();
          chk("sb_p", p, exp_p);
        end
      end
    end
  end

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called just after a falling edge; pulses start for one cycle.
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib,
                        input logic [31:0] exp, input string name);
    bit ok;
    start = 1'b1; a = ia; b = ib;
    @(negedge clk);
    start = 1'b0; a = 16'($urandom); b = 16'($urandom);
    wait_done(ok);
    chk({name, "_seen"}, {31'b0, ok}, 32'd1);
    chk(name, p, exp);
  endtask

  initial begin
    bit ok;
    int d1, d2, nd;
    #3;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_p", p, 32'd0);

    // start held across reset is ignored until the first edge after release
    start = 1'b1; a = 16'd5; b = 16'd6;
    repeat (2) @(negedge clk);
    chk("rst_ign_busy", {31'b0, busy}, 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("first_accept", {31'b0, busy}, 32'd1);
    wait_done(ok);
    chk("p_5x6", p, 32'd30);
    @(negedge clk);

    run_op(16'd31, 16'd11121, 32'h0005_42AF, "p_31x11121");
    repeat (5) @(negedge clk);
    chk("p_hold", p, 32'h0005_42AF);

    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "p_ffff_sq");
    run_op(16'h0000, 16'h1234, 32'h0000_0000, "p_zero");
    @(negedge clk);

    // start held high: back-to-back operations with a 17-cycle period
    start = 1'b1; a = 16'd3; b = 16'd5;
    d1 = 0; d2 = 0; nd = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (nd == 1) d1 = i;
        if (nd == 2) d2 = i;
        chk("p_3x5", p, 32'd15);
      end
    end
    start = 1'b0;
    chk("b2b_done1", d1, 32'd17);
    chk("b2b_done2", d2, 32'd34);
    wait_done(ok);
    chk("b2b_third", {31'b0, ok}, 32'd1);
    @(negedge clk);

    // start during RUN is ignored
    start = 1'b1; a = 16'd2; b = 16'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; a = 16'd9; b = 16'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done(ok);
    chk("p_ign_start", p, 32'd14);
    @(negedge clk);

    // asynchronous reset in the middle of RUN
    start = 1'b1; a = 16'd1234; b = 16'd4321;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_p", p, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("arst_no_done", nd, 32'd0);
    run_op(16'd1234, 16'd4321, 32'd5332114, "p_after_rst");

    // randomized traffic, including starts during RUN and DONE
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start = ($urandom_range(3) == 0);
      case ($urandom_range(7))
        0: a = 16'hFFFF;
        1: a = 16'h0000;
        default: a = 16'($urandom);
      endcase
      case ($urandom_range(7))
        0: b = 16'hFFFF;
        1: b = 16'h0001;
        default: b = 16'($urandom);
      endcase
    end
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_16_seq.md
MULT_16_SEQ -- requirements
Module: mult_16_seq

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed at 16-bit operands and 32-bit product.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin a multiply; sampled on the rising edge of clk.
REQ-005 a  input  16  multiplicand, unsigned; sampled with an accepted start.
REQ-006 b  input  16  multiplier, unsigned; sampled with an accepted start.
REQ-007 busy  output  1  high while a multiply is in progress.
REQ-008 done  output  1  one-cycle pulse marking that p holds a new result.
REQ-009 p  output  32  unsigned product a*b of the most recently completed operation.

Function
REQ-010 The block SHALL be an FSM with three states: IDLE, RUN and DONE.
REQ-011 start SHALL be accepted when the state is IDLE or DONE.
- On acceptance: latch a into the multiplicand register (mc), b into the low half of the accumulator (acc[15:0]), clear acc[31:16] and the bit counter, and enter RUN.
REQ-012 start SHALL be ignored in RUN.
- a and b changes during RUN have no effect.
REQ-013 Each RUN cycle SHALL perform one shift-add step.
- If acc[0]=1: {c,s} = acc[31:16] + mc, a 16-bit add with carry-out c; otherwise {c,s} = {0, acc[31:16]}.
- Then acc <= {c, s, acc[15:1]}.
REQ-014 The carry-out c SHALL be retained as the new acc[31] on every step; no carry SHALL be lost.
REQ-015 RUN SHALL last exactly 16 cycles, counted by a 4-bit counter that increments once per step.
- On the step with counter=15, the state SHALL go to DONE and p SHALL load the final acc value on the same edge.
REQ-016 Latency SHALL be fixed at 16 cycles.
- With start accepted at edge k, p is valid and done=1 during the cycle following edge k+16.
- This holds regardless of operand values, with no early termination.
REQ-017 busy SHALL be 1 exactly in RUN, i.e. for 16 cycles per operation.
REQ-018 done SHALL be 1 exactly in DONE, for one cycle.
- DONE returns to IDLE at the next edge unless start=1, in which case a new operation begins.
- This allows back-to-back operations with a 17-cycle period.
REQ-019 p SHALL change only on the RUN-to-DONE edge and on reset.
- p holds its value through IDLE and through any subsequent RUN until the next completion.
REQ-020 The product SHALL equal a*b exactly for all operand values (full 32-bit result, no overflow possible).

Reset
REQ-021 When rst=1, regardless of clk, the block SHALL enter IDLE and clear p, acc, mc and the counter to 0, with busy=0 and done=0.
REQ-022 Reset asserted during RUN SHALL abort the operation.
- No done pulse and no update of p other than clearing to 0.
REQ-023 start SHALL be ignored in any cycle in which rst=1.
- The first accept is possible on the first rising edge after rst deasserts.

Verification
REQ-024 a=31, b=11121, start pulsed one cycle -> busy=1 for 16 cycles, then done=1 for one cycle with p=0x000542AF; p holds afterwards.
REQ-025 a=0xFFFF, b=0xFFFF -> p=0xFFFE0001 at done, exercising carry-out on every step; then a=0, b=0x1234 -> p=0x00000000.
REQ-026 start=1 held for 40 cycles with a=3, b=5 -> done pulses at cycles 17 and 34 relative to the first accept, p=15 each time, busy low only during the DONE cycles.
REQ-027 start with a=2, b=7, then start pulsed at RUN cycle 5 with a=9, b=9 -> second start ignored, p=14 at done.
REQ-028 rst asserted asynchronously (mid-cycle) at RUN cycle 8 -> busy, done and p go to 0 immediately, the state is IDLE, and no done pulse follows; a new start then completes normally with the correct product.
